exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exc_pkg.sv | 27 ++
 rtl/exc_regs.sv | 32 +++
 rtl/exception_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : exc_pkg
// | Brief    : Shared state encoding, cause codes and default vector for exception_ctrl.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_ENTER   = 3'd2,
        S_HANDLER = 3'd3,
        S_RETURN  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [3:0]  CAUSE_UNDEF    = 4'd1;
    localparam logic [3:0]  CAUSE_IRQ      = 4'd2;
    localparam logic [3:0]  CAUSE_ERET     = 4'd3;

    localparam logic [63:0] DEFAULT_VECTOR = 64'h0000_0000_0000_00D8;

endpackage

`default_nettype wire

// File: rtl/exc_regs.sv
// +-----------------------------------------------------------------------------
// | Module   : exc_regs
// | Brief    : Exception link register (ELR) and syndrome register (ESR) capture.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module exc_regs
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic [63:0] pc,
    input  logic [3:0]  cause,
    output logic [63:0] elr,
    output logic [3:0]  esr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr <= '0;
            esr <= '0;
        end else if (capture) begin
            elr <= pc;
            esr <= cause;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// +-----------------------------------------------------------------------------
// | Module   : exception_ctrl
// | Brief    : Pipeline exception sequencer: flush, vector redirect, handler, ERET, halt.
// |            Macro EXC_IRQ_EN enables external interrupt acceptance.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [63:0] VECTOR_ADDR  = DEFAULT_VECTOR,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        NotAnInstr,
    input  logic        ERet,
    input  logic        ExtIRQ,
    input  logic [63:0] PC_in,
    output logic        Flush,
    output logic        ExcRedirect,
    output logic [63:0] ExcVector,
    output logic        ERetRedirect,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        InExc,
    output logic        IrqAck,
    output logic        Halt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       capture;
    logic [3:0] cause;
    logic       irq_req;

`ifdef EXC_IRQ_EN
    assign irq_req = ExtIRQ;
`else
    // Interrupt port stays on the interface but can never win arbitration.
    assign irq_req = ExtIRQ & 1'b0;
`endif

    assign ExcVector = VECTOR_ADDR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        capture      = 1'b0;
        cause        = CAUSE_UNDEF;
        Flush        = 1'b0;
        ExcRedirect  = 1'b0;
        ERetRedirect = 1'b0;
        InExc        = 1'b0;
        IrqAck       = 1'b0;
        Halt         = 1'b0;
        case (state)
            S_IDLE: begin
                if (NotAnInstr) begin
                    capture = 1'b1;
                    cause   = CAUSE_UNDEF;
                end else if (ERet) begin
                    capture = 1'b1;
                    cause   = CAUSE_ERET;
                end else if (irq_req) begin
                    capture = 1'b1;
                    cause   = CAUSE_IRQ;
                    IrqAck  = 1'b1;
                end
                if (capture) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                Flush = 1'b1;
                if (cnt == 3'd0) begin
                    state_nxt = S_ENTER;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            S_ENTER: begin
                Flush       = 1'b1;
                ExcRedirect = 1'b1;
                state_nxt   = S_HANDLER;
            end
            S_HANDLER: begin
                InExc = 1'b1;
                // A fault inside the handler is unrecoverable and beats ERET.
                if (NotAnInstr) begin
                    state_nxt = S_HALT;
                end else if (ERet) begin
                    state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                Flush        = 1'b1;
                ERetRedirect = 1'b1;
                state_nxt    = S_IDLE;
            end
            S_HALT: begin
                Flush = 1'b1;
                Halt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    exc_regs u_exc_regs (
        .clk     (clk),
        .reset   (reset),
        .capture (capture),
        .pc      (PC_in),
        .cause   (cause),
        .elr     (ELR),
        .esr     (ESR)
    );

endmodule

`default_nettype wire
